wheel_encoder: RTL and testbench
================================

# wheel_encoder

Quadrature decoder for the two wheel encoders (ELA/ELB, ERA/ERB) on the robot chassis. It is the feedback path for the motor driver block. Per wheel it synchronizes the A/B pins, decodes x4 quadrature steps into a signed position count, and tracks the last direction and any illegal transitions. It also measures signed speed as edges per fixed sample window, with a one-cycle valid strobe at the end of each window. The outputs feed the drive/steering controller.

## Interface
- CLK_HZ, 12_000_000: system clock frequency; informational only, not used in arithmetic.
- WINDOW_CYCLES, 1_200_000: speed sample window length in clocks (100 ms at 12 MHz); must be ≥ 2.
- CNT_W, 16: position counter width, signed.
- SPD_W, 12: speed output width, signed.
- INVERT_L, 0: when 1, negate the left wheel step sign.
- INVERT_R, 0: when 1, negate the right wheel step sign.
- clk  in  1  system clock; all logic on its rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- ela, elb  in  1 each  left encoder A/B; asynchronous pins.
- era, erb  in  1 each  right encoder A/B; asynchronous pins.
- clr  in  1  synchronous clear of positions and error flags.
- pos_l, pos_r  out  CNT_W  signed position count, in quadrature edges.
- spd_l, spd_r  out  SPD_W  signed edges counted in the last completed window.
- spd_valid  out  1  one-cycle pulse when spd_l and spd_r update.
- dir_l, dir_r  out  1  direction of the last valid step; 0 = forward (+), 1 = reverse (−).
- err_l, err_r  out  1  sticky; set by an illegal transition.

## Operation
- Reset values of all outputs: pos 0, spd 0, spd_valid 0, dir 0, err 0. Synchronizers, prev-state registers, accumulators and the window counter also reset to 0.
- Per wheel input path: 2-FF synchronizer on {A,B}, then a prev-state register. The decoder compares the current synchronized state (cur) against prev every cycle.
- Gray sequence 00→01→11→10→00 is a +1 step; the reverse order is a −1 step. The sign is then negated if INVERT_x=1.
- cur == prev: no step.
- Both bits change in one cycle: no count and no dir change; err_x is set.
- Priming after reset release: decode is suppressed for the first 3 clocks while prev loads from cur. This prevents a false error when the pins idle at a nonzero state.
- Valid step: pos_x ← pos_x ± 1 with two's-complement wrap (0x7FFF + 1 → 0x8000). dir_x takes the step sign.
- clr=1: pos_x ← 0 and err_x ← 0. clr wins over a simultaneous step. dir, the speed accumulators and the window counter are unaffected.
- Speed path: window counter runs 0..WINDOW_CYCLES−1 and wraps. Each wheel has a signed SPD_W accumulator that adds the per-cycle step. The accumulator saturates at +2^(SPD_W−1)−1 and −2^(SPD_W−1), with no wrap.
- At window terminal count: spd_x ← the accumulator value including the current cycle's step; spd_valid pulses high for 1 cycle; the accumulator ← 0.

## Timing
- Pin transition stable before edge N: pos_x, dir_x and err_x update on edge N+2 and are visible after it.
- Maximum countable rate is 1 step per clock. Faster pin activity produces double-bit changes, which set err_x.
- The first spd_valid occurs on edge WINDOW_CYCLES after reset release; after that, every WINDOW_CYCLES clocks.
- spd_valid is registered and coincides with the spd_x update.
- Reset assertion mid-operation immediately forces all outputs to reset values. Priming restarts on release.

## Structure
- encoder_pkg: step_t enum (STEP_NONE, STEP_FWD, STEP_REV, STEP_ERR) and the decode_step() function mapping {prev,cur} to step_t.
- Sub-module quad_decoder, instantiated twice. It contains the synchronizer, prev register, priming, position counter, dir, err and saturating accumulator.
- The top level holds the shared window counter and distributes the terminal-count strobe to both instances.

## Test plan
- Reset with ela/elb = 11, release, hold pins: after 10 clocks pos_l = 0, err_l = 0, no spurious count.
- Left sequence 00→01→11→10→00 ×4, each state held 5 clocks: pos_l = +16, dir_l = 0. Run the reverse sequence ×4: pos_l = 0, dir_l = 1.
- Right pins jump 00→11 in one clock: err_r = 1 and pos_r unchanged. Then assert clr: err_r = 0, pos_r = 0. clr together with a step: pos_r = 0.
- pos_l preloaded to 0x7FFF via 32767 forward steps, then one more step: pos_l = 0x8000.
- WINDOW_CYCLES = 100 with 37 forward right steps in a window: spd_r = 37 and spd_valid high exactly on cycle 100. A step on the terminal cycle is counted in that window.
- SPD_W = 4 with 20 forward steps in a window: spd = +7 (saturated). With INVERT_L = 1, forward steps give pos_l negative.

Source files
------------

// File: rtl/wheel_encoder_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : wheel_encoder_pkg
//  Description : Shared types and helpers for the wheel quadrature decoder.
//                step_t classifies one sampled transition of an {A,B} pair;
//                decode_step() maps {prev,cur} onto that classification.
//  Revision    : 1.0 - initial release
// ============================================================================
package wheel_encoder_pkg;

   typedef enum logic [1:0] {
      STEP_NONE = 2'd0,
      STEP_FWD  = 2'd1,
      STEP_REV  = 2'd2,
      STEP_ERR  = 2'd3
   } step_t;

   // Priming counter value at which decoding is enabled (3 clocks after reset).
   localparam logic [1:0] PRIME_DONE = 2'd3;

   // Gray order 00 -> 01 -> 11 -> 10 -> 00 is forward ({A,B} bit order).
   // Any change of both bits in one sample is an illegal transition.
   function automatic step_t decode_step(input logic [1:0] prev, input logic [1:0] cur);
      step_t s;
      case ({prev, cur})
         4'b0001, 4'b0111, 4'b1110, 4'b1000: s = STEP_FWD;
         4'b0100, 4'b1101, 4'b1011, 4'b0010: s = STEP_REV;
         4'b0000, 4'b0101, 4'b1111, 4'b1010: s = STEP_NONE;
         default:                            s = STEP_ERR;
      endcase
      return s;
   endfunction

endpackage
`default_nettype wire

// File: rtl/wheel_encoder_quad_decoder.sv
`default_nettype none
// ============================================================================
//  Module      : wheel_encoder_quad_decoder
//  Description : One wheel of the quadrature decoder. Synchronizes the A/B
//                pins, decodes x4 steps into a wrapping position count, keeps
//                last direction and a sticky illegal-transition flag, and
//                accumulates a saturating per-window speed.
//  Ports       : clk_i, rst_ni  - clock, asynchronous active-low reset
//                a_i, b_i       - raw encoder pins (asynchronous)
//                clr_i          - synchronous clear of position and error
//                tc_i           - window terminal-count strobe from the top
//                pos_o          - signed position in quadrature edges
//                spd_o          - signed edges in the last completed window
//                dir_o          - last valid step direction (1 = reverse)
//                err_o          - sticky illegal-transition flag
//  Revision    : 1.0 - initial release
// ============================================================================
module wheel_encoder_quad_decoder
   import wheel_encoder_pkg::*;
#(
   parameter int CNT_W  = 16,
   parameter int SPD_W  = 12,
   parameter bit INVERT = 1'b0
) (
   input  logic                    clk_i,
   input  logic                    rst_ni,
   input  logic                    a_i,
   input  logic                    b_i,
   input  logic                    clr_i,
   input  logic                    tc_i,
   output logic signed [CNT_W-1:0] pos_o,
   output logic signed [SPD_W-1:0] spd_o,
   output logic                    dir_o,
   output logic                    err_o
);

   localparam logic [CNT_W-1:0] POS_ONE = CNT_W'(1);
   localparam logic [SPD_W-1:0] ACC_ONE = SPD_W'(1);
   localparam logic [SPD_W-1:0] ACC_MAX = {1'b0, {(SPD_W-1){1'b1}}};
   localparam logic [SPD_W-1:0] ACC_MIN = {1'b1, {(SPD_W-1){1'b0}}};

   logic [1:0]       sync1_q, sync2_q, prev_q;
   logic [1:0]       prime_q, prime_d;
   logic [CNT_W-1:0] pos_q, pos_d;
   logic [SPD_W-1:0] acc_q, acc_d, spd_q, spd_d, acc_sum;
   logic             dir_q, dir_d, err_q, err_d;

   step_t            step_w;
   logic             step_vld_w, step_up_w;

   // Decode is held off until prev has been loaded from a settled cur, so an
   // idle nonzero pin state after reset does not look like a double-bit jump.
   always_comb begin
      step_w = STEP_NONE;
      if (prime_q == PRIME_DONE) begin
         step_w = decode_step(prev_q, sync2_q);
      end
      step_vld_w = (step_w == STEP_FWD) || (step_w == STEP_REV);
      step_up_w  = (step_w == STEP_FWD) ^ INVERT;
   end

   always_comb begin
      prime_d = (prime_q == PRIME_DONE) ? prime_q : prime_q + 2'd1;
      pos_d   = pos_q;
      dir_d   = dir_q;
      err_d   = err_q;
      acc_sum = acc_q;

      if (step_vld_w) begin
         pos_d = step_up_w ? pos_q + POS_ONE : pos_q - POS_ONE;
         dir_d = ~step_up_w;
         // Speed accumulator clamps at the signed limits instead of wrapping.
         if (step_up_w && (acc_q != ACC_MAX)) begin
            acc_sum = acc_q + ACC_ONE;
         end else if (!step_up_w && (acc_q != ACC_MIN)) begin
            acc_sum = acc_q - ACC_ONE;
         end
      end

      if (step_w == STEP_ERR) begin
         err_d = 1'b1;
      end

      // Clear beats a simultaneous step; dir and speed path keep running.
      if (clr_i) begin
         pos_d = '0;
         err_d = 1'b0;
      end

      // The terminal cycle's own step is included in the published value.
      acc_d = tc_i ? '0      : acc_sum;
      spd_d = tc_i ? acc_sum : spd_q;
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         sync1_q <= '0;
         sync2_q <= '0;
         prev_q  <= '0;
         prime_q <= '0;
         pos_q   <= '0;
         dir_q   <= 1'b0;
         err_q   <= 1'b0;
         acc_q   <= '0;
         spd_q   <= '0;
      end else begin
         sync1_q <= {a_i, b_i};
         sync2_q <= sync1_q;
         prev_q  <= sync2_q;
         prime_q <= prime_d;
         pos_q   <= pos_d;
         dir_q   <= dir_d;
         err_q   <= err_d;
         acc_q   <= acc_d;
         spd_q   <= spd_d;
      end
   end

   assign pos_o = pos_q;
   assign spd_o = spd_q;
   assign dir_o = dir_q;
   assign err_o = err_q;

endmodule
`default_nettype wire

// File: rtl/wheel_encoder.sv
`default_nettype none
// ============================================================================
//  Module      : wheel_encoder
//  Description : Dual-wheel quadrature decoder. Two per-wheel decoders share
//                one speed sample window counter whose terminal count latches
//                both speeds and raises a one-cycle spd_valid_o.
//  Ports       : clk_i, rst_ni         - clock, asynchronous active-low reset
//                ela_i/elb_i, era_i/erb_i - left/right encoder pins
//                clr_i                 - clear positions and error flags
//                pos_l_o, pos_r_o      - signed positions
//                spd_l_o, spd_r_o      - signed edges per window
//                spd_valid_o           - speed update strobe
//                dir_l_o, dir_r_o      - last step direction (1 = reverse)
//                err_l_o, err_r_o      - sticky illegal-transition flags
//  Revision    : 1.0 - initial release
// ============================================================================
module wheel_encoder #(
   parameter int CLK_HZ        = 12_000_000,
   parameter int WINDOW_CYCLES = 1_200_000,
   parameter int CNT_W         = 16,
   parameter int SPD_W         = 12,
   parameter int INVERT_L      = 0,
   parameter int INVERT_R      = 0
) (
   input  logic                    clk_i,
   input  logic                    rst_ni,
   input  logic                    ela_i,
   input  logic                    elb_i,
   input  logic                    era_i,
   input  logic                    erb_i,
   input  logic                    clr_i,
   output logic signed [CNT_W-1:0] pos_l_o,
   output logic signed [CNT_W-1:0] pos_r_o,
   output logic signed [SPD_W-1:0] spd_l_o,
   output logic signed [SPD_W-1:0] spd_r_o,
   output logic                    spd_valid_o,
   output logic                    dir_l_o,
   output logic                    dir_r_o,
   output logic                    err_l_o,
   output logic                    err_r_o
);

   logic tc_w;
   logic spd_valid_q;

   generate
      if (WINDOW_CYCLES >= 2 && CLK_HZ > 0) begin : g_window
         localparam int               WIN_W    = $clog2(WINDOW_CYCLES);
         localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(WINDOW_CYCLES - 1);

         logic [WIN_W-1:0] win_q, win_d;

         assign tc_w  = (win_q == WIN_LAST);
         assign win_d = tc_w ? '0 : win_q + WIN_W'(1);

         always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
               win_q <= '0;
            end else begin
               win_q <= win_d;
            end
         end
      end else begin : g_no_window
         // Invalid configuration: speed path never publishes.
         assign tc_w = 1'b0;
      end
   endgenerate

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         spd_valid_q <= 1'b0;
      end else begin
         spd_valid_q <= tc_w;
      end
   end

   assign spd_valid_o = spd_valid_q;

   wheel_encoder_quad_decoder #(
      .CNT_W  (CNT_W),
      .SPD_W  (SPD_W),
      .INVERT (INVERT_L != 0)
   ) u_dec_l (
      .clk_i  (clk_i),
      .rst_ni (rst_ni),
      .a_i    (ela_i),
      .b_i    (elb_i),
      .clr_i  (clr_i),
      .tc_i   (tc_w),
      .pos_o  (pos_l_o),
      .spd_o  (spd_l_o),
      .dir_o  (dir_l_o),
      .err_o  (err_l_o)
   );

   wheel_encoder_quad_decoder #(
      .CNT_W  (CNT_W),
      .SPD_W  (SPD_W),
      .INVERT (INVERT_R != 0)
   ) u_dec_r (
      .clk_i  (clk_i),
      .rst_ni (rst_ni),
      .a_i    (era_i),
      .b_i    (erb_i),
      .clr_i  (clr_i),
      .tc_i   (tc_w),
      .pos_o  (pos_r_o),
      .spd_o  (spd_r_o),
      .dir_o  (dir_r_o),
      .err_o  (err_r_o)
   );

endmodule
`default_nettype wire

// File: tb/tb_wheel_encoder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_wheel_encoder
//  Description : Self-checking bench for wheel_encoder. A behavioural model
//                tracks pin states in Gray-index terms; expected speeds are
//                queued per window and compared when spd_valid_o fires.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_wheel_encoder;

   localparam int W     = 100;
   localparam int CW    = 16;
   localparam int SW    = 6;
   localparam bit INV_L = 1'b0;
   localparam bit INV_R = 1'b1;
   localparam int SMAX  = (1 << (SW - 1)) - 1;
   localparam int SMIN  = -(1 << (SW - 1));

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst_n, ela, elb, era, erb, clr;
   logic signed [CW-1:0] pos_l, pos_r;
   logic signed [SW-1:0] spd_l, spd_r;
   logic spd_valid, dir_l, dir_r, err_l, err_r;

   wheel_encoder #(
      .CLK_HZ        (12_000_000),
      .WINDOW_CYCLES (W),
      .CNT_W         (CW),
      .SPD_W         (SW),
      .INVERT_L      (int'(INV_L)),
      .INVERT_R      (int'(INV_R))
   ) dut (
      .clk_i       (clk),
      .rst_ni      (rst_n),
      .ela_i       (ela),
      .elb_i       (elb),
      .era_i       (era),
      .erb_i       (erb),
      .clr_i       (clr),
      .pos_l_o     (pos_l),
      .pos_r_o     (pos_r),
      .spd_l_o     (spd_l),
      .spd_r_o     (spd_r),
      .spd_valid_o (spd_valid),
      .dir_l_o     (dir_l),
      .dir_r_o     (dir_r),
      .err_l_o     (err_l),
      .err_r_o     (err_r)
   );

   int checks = 0;
   int errors = 0;

   // ---------------- reference model state ----------------
   logic [1:0]           pin_l, pin_r;
   logic signed [CW-1:0] mpos_l, mpos_r;
   logic                 mdir_l, mdir_r, merr_l, merr_r;
   int                   ecnt;            // clock edges since reset release
   int                   acc_l[int];      // per-window speed, keyed by window
   int                   acc_r[int];

   typedef struct {
      int edge_n;
      int l;
      int r;
   } spd_t;
   spd_t spq[$];

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   function automatic int gidx(input logic [1:0] s);
      case (s)
         2'b00:   return 0;
         2'b01:   return 1;
         2'b11:   return 2;
         default: return 3;
      endcase
   endfunction

   function automatic logic [1:0] gstate(input int i);
      case (i & 3)
         0:       return 2'b00;
         1:       return 2'b01;
         2:       return 2'b11;
         default: return 2'b10;
      endcase
   endfunction

   function automatic int sat_add(input int a, input int s);
      int v;
      v = a + s;
      if (v > SMAX) v = SMAX;
      if (v < SMIN) v = SMIN;
      return v;
   endfunction

   // A pin change driven after edge ecnt is reflected on edge ecnt+3.
   task automatic model_step(input bit left, input logic [1:0] nw);
      int d, s, k, a;
      d = (gidx(nw) - gidx(left ? pin_l : pin_r)) & 3;
      s = (d == 1) ? 1 : (d == 3) ? -1 : 0;
      if (left ? INV_L : INV_R) s = -s;
      k = (ecnt + 3 - 1) / W;
      if (d == 2) begin
         if (left) merr_l = 1'b1; else merr_r = 1'b1;
      end else if (s != 0) begin
         if (left) begin
            mpos_l = mpos_l + CW'(s);
            mdir_l = (s < 0);
            a = acc_l.exists(k) ? acc_l[k] : 0;
            acc_l[k] = sat_add(a, s);
         end else begin
            mpos_r = mpos_r + CW'(s);
            mdir_r = (s < 0);
            a = acc_r.exists(k) ? acc_r[k] : 0;
            acc_r[k] = sat_add(a, s);
         end
      end
      if (left) pin_l = nw; else pin_r = nw;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [1:0] nl, input logic [1:0] nr);
      model_step(1'b1, nl);
      model_step(1'b0, nr);
      {ela, elb} = nl;
      {era, erb} = nr;
   endtask

   task automatic pulse_clr();
      clr = 1'b1;
      mpos_l = '0; mpos_r = '0; merr_l = 1'b0; merr_r = 1'b0;
      tick();
      clr = 1'b0;
   endtask

   task automatic check_model(input string tag);
      chk({tag, "_pos_l"}, int'(pos_l), int'(mpos_l));
      chk({tag, "_pos_r"}, int'(pos_r), int'(mpos_r));
      chk({tag, "_dir_l"}, int'(dir_l), int'(mdir_l));
      chk({tag, "_dir_r"}, int'(dir_r), int'(mdir_r));
      chk({tag, "_err_l"}, int'(err_l), int'(merr_l));
      chk({tag, "_err_r"}, int'(err_r), int'(merr_r));
   endtask

   // Model clock: counts edges and queues the expected speed of each window.
   initial begin
      ecnt = 0;
      forever begin
         @(posedge clk);
         if (rst_n === 1'b1) begin
            spd_t e;
            int   k;
            ecnt++;
            if (ecnt % W == 0) begin
               k        = ecnt / W - 1;
               e.edge_n = ecnt;
               e.l      = acc_l.exists(k) ? acc_l[k] : 0;
               e.r      = acc_r.exists(k) ? acc_r[k] : 0;
               spq.push_back(e);
            end
         end else begin
            ecnt = 0;
         end
      end
   end

   // Monitor: compares published speeds against the queued expectations.
   initial begin
      forever begin
         @(negedge clk);
         if (rst_n === 1'b1) begin
            if (spd_valid === 1'b1) begin
               if (spq.size() == 0) begin
                  chk("spd_valid_unexpected", 1, 0);
               end else begin
                  spd_t e;
                  e = spq.pop_front();
                  chk("spd_edge", ecnt, e.edge_n);
                  chk("spd_l", int'(spd_l), e.l);
                  chk("spd_r", int'(spd_r), e.r);
               end
            end else if (spq.size() > 0 && spq[0].edge_n == ecnt) begin
               chk("spd_valid_missing", int'(spd_valid), 1);
               void'(spq.pop_front());
            end
         end
      end
   end

   initial begin
      #5_000_000;
      errors++;
      $display("FAIL watchdog: got timeout expected completion");
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      rst_n = 1'b0; clr = 1'b0;
      {ela, elb} = 2'b11; {era, erb} = 2'b00;
      pin_l = 2'b11; pin_r = 2'b00;
      mpos_l = '0; mpos_r = '0;
      mdir_l = 1'b0; mdir_r = 1'b0; merr_l = 1'b0; merr_r = 1'b0;
      repeat (3) tick();
      chk("rst_pos_l", int'(pos_l), 0);
      chk("rst_spd_l", int'(spd_l), 0);
      chk("rst_valid", int'(spd_valid), 0);
      chk("rst_err_l", int'(err_l), 0);

      // Idle at 11 through release: priming must hide the nonzero state.
      rst_n = 1'b1;
      repeat (10) tick();
      chk("prime_pos_l", int'(pos_l), 0);
      chk("prime_err_l", int'(err_l), 0);
      check_model("prime");

      for (int i = 0; i < 16; i++) begin
         drive(gstate(gidx(pin_l) + 1), pin_r);
         repeat (5) tick();
      end
      chk("fwd16_pos_l", int'(pos_l), 16);
      chk("fwd16_dir_l", int'(dir_l), 0);
      check_model("fwd16");

      for (int i = 0; i < 16; i++) begin
         drive(gstate(gidx(pin_l) - 1), pin_r);
         repeat (5) tick();
      end
      chk("rev16_pos_l", int'(pos_l), 0);
      chk("rev16_dir_l", int'(dir_l), 1);

      // Double-bit jump on the right wheel.
      drive(pin_l, pin_r ^ 2'b11);
      repeat (4) tick();
      chk("jump_err_r", int'(err_r), 1);
      check_model("jump");
      pulse_clr();
      repeat (3) tick();
      chk("clr_err_r", int'(err_r), 0);
      check_model("clr");

      // Step landing on the same edge as clr: clear wins.
      drive(pin_l, gstate(gidx(pin_r) + 1));
      tick();
      tick();
      pulse_clr();
      repeat (3) tick();
      chk("clrstep_pos_r", int'(pos_r), 0);
      check_model("clrstep");

      for (int i = 0; i < 37; i++) begin
         drive(pin_l, gstate(gidx(pin_r) + 1));
         repeat (2) tick();
      end
      repeat (3) tick();
      check_model("r37");

      for (int b = 0; b < 8; b++) begin
         for (int i = 0; i < 40; i++) begin
            logic [1:0] nl, nr;
            int rl, rr;
            rl = $urandom_range(0, 9);
            rr = $urandom_range(0, 9);
            nl = (rl < 4) ? pin_l : (rl < 7) ? gstate(gidx(pin_l) + 1) :
                 (rl < 9) ? gstate(gidx(pin_l) - 1) : (pin_l ^ 2'b11);
            nr = (rr < 4) ? pin_r : (rr < 7) ? gstate(gidx(pin_r) + 1) :
                 (rr < 9) ? gstate(gidx(pin_r) - 1) : (pin_r ^ 2'b11);
            drive(nl, nr);
            repeat ($urandom_range(1, 4)) tick();
         end
         repeat (3) tick();
         check_model("rand");
         pulse_clr();
         repeat (3) tick();
      end

      // Position wrap: 0x7FFF then one more forward step.
      pulse_clr();
      repeat (3) tick();
      for (int i = 0; i < 32767; i++) begin
         drive(gstate(gidx(pin_l) + 1), pin_r);
         tick();
      end
      repeat (3) tick();
      chk("wrap_max_pos_l", int'(pos_l), 32767);
      drive(gstate(gidx(pin_l) + 1), pin_r);
      repeat (3) tick();
      chk("wrap_min_pos_l", int'(pos_l), -32768);
      check_model("wrap");

      repeat (2 * W) tick();
      @(negedge clk);
      #1;
      chk("spd_queue_empty", spq.size(), 0);

      // Asynchronous reset mid-operation.
      rst_n = 1'b0;
      #1;
      chk("arst_pos_l", int'(pos_l), 0);
      chk("arst_spd_l", int'(spd_l), 0);
      chk("arst_dir_l", int'(dir_l), 0);
      chk("arst_valid", int'(spd_valid), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
